// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I execute datapath: opcodes, operation enums and
// the ALU / branch-compare helpers used by rv32i_exec_datapath.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } br_op_t;

  typedef enum logic [1:0] {
    JUMP_SEQ    = 2'b00,
    JUMP_JAL    = 2'b01,
    JUMP_JALR   = 2'b10,
    JUMP_BRANCH = 2'b11
  } jump_t;

  // funct3 selects the operation; alt (funct7[5]) turns ADD/SRL into SUB/SRA.
  function automatic alu_op_t f3_to_alu(logic [2:0] f3, logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic br_cmp(br_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      BR_NE:   return a != b;
      BR_LT:   return $signed(a) < $signed(b);
      BR_GE:   return $signed(a) >= $signed(b);
      BR_LTU:  return a < b;
      BR_GEU:  return a >= b;
      default: return a == b;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 register file, two asynchronous read ports, one write port, synchronous clear.
// Define REGFILE_BYPASS_EN to make same-cycle reads of the written register see the new value.
module rv32i_regfile (
  input  logic        i_clk,
  input  logic        nreset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  // NOTE: the array is cleared in a reset loop because architectural state must
  // start at zero; x0 is cleared too but its reads are forced to zero regardless.
  always_ff @(posedge i_clk) begin
    if (!nreset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      // NOTE: non-blocking so the same-edge reads elsewhere see the pre-edge value.
      regs[waddr] <= wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
    if (we && waddr != 5'd0 && waddr == raddr1) rdata1 = wdata;
    if (we && waddr != 5'd0 && waddr == raddr2) rdata2 = wdata;
  end
`else
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
`endif

endmodule

// File: rtl/rv32i_exec_datapath.sv
// Single-cycle RV32I execute stage: decode, register file, ALU, branch compare and next PC.
// REGFILE_BYPASS_EN (see rv32i_regfile) selects write-through register reads.
module rv32i_exec_datapath
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        nreset,
  input  logic [31:0] i_insn,
  input  logic [31:0] i_pc,
  input  logic        i_wb_en,
  input  logic [31:0] i_load_data,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_store_data,
  output logic        o_load,
  output logic        o_store,
  output logic [1:0]  o_jump,
  output logic        o_cond,
  output logic [31:0] o_next_pc,
  output logic        o_illegal
);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = i_insn[6:0];
  assign rd     = i_insn[11:7];
  assign funct3 = i_insn[14:12];
  assign rs1    = i_insn[19:15];
  assign rs2    = i_insn[24:20];
  assign funct7 = i_insn[31:25];

  assign imm_i = {{20{i_insn[31]}}, i_insn[31:20]};
  assign imm_s = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
  assign imm_b = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
  assign imm_u = {i_insn[31:12], 12'd0};
  assign imm_j = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};

  alu_op_t     alu_op;
  br_op_t      br_op;
  jump_t       jump;
  logic        legal, writes_rd, is_load, is_store, use_rs2, a_is_pc, a_is_zero;
  logic [31:0] imm;

  // NOTE: every decode output gets a default first so no path leaves one unassigned.
  always_comb begin
    alu_op    = ALU_ADD;
    br_op     = BR_EQ;
    jump      = JUMP_SEQ;
    legal     = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    use_rs2   = 1'b0;
    a_is_pc   = 1'b0;
    a_is_zero = 1'b0;
    imm       = imm_i;
    case (opcode)
      OPC_LUI:   begin legal = 1'b1; writes_rd = 1'b1; a_is_zero = 1'b1; imm = imm_u; end
      OPC_AUIPC: begin legal = 1'b1; writes_rd = 1'b1; a_is_pc = 1'b1; imm = imm_u; end
      OPC_JAL:   begin legal = 1'b1; writes_rd = 1'b1; jump = JUMP_JAL; imm = imm_j; end
      OPC_JALR:  begin legal = (funct3 == 3'd0); writes_rd = 1'b1; jump = JUMP_JALR; end
      OPC_BRANCH: begin
        legal = (funct3 != 3'd2) && (funct3 != 3'd3);
        jump  = JUMP_BRANCH;
        imm   = imm_b;
        case (funct3)
          3'd1:    br_op = BR_NE;
          3'd4:    br_op = BR_LT;
          3'd5:    br_op = BR_GE;
          3'd6:    br_op = BR_LTU;
          3'd7:    br_op = BR_GEU;
          default: br_op = BR_EQ;
        endcase
      end
      OPC_LOAD:  begin legal = (funct3 == 3'd2); writes_rd = 1'b1; is_load = 1'b1; end
      OPC_STORE: begin legal = (funct3 == 3'd2); is_store = 1'b1; imm = imm_s; end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        alu_op    = f3_to_alu(funct3, (funct3 == 3'd5) && funct7[5]);
        case (funct3)
          3'd1:    legal = (funct7 == 7'h00);
          3'd5:    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        use_rs2   = 1'b1;
        alu_op    = f3_to_alu(funct3, funct7[5]);
        legal     = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && (funct3 == 3'd0 || funct3 == 3'd5));
      end
      OPC_MISC_MEM: legal = (funct3 == 3'd0);
      default: ;
    endcase
  end

  logic [31:0] rs1_val, rs2_val, op_a, op_b, alu_res, wb_data, pc_plus4;
  logic        taken, we;

  assign op_a     = a_is_zero ? 32'd0 : (a_is_pc ? i_pc : rs1_val);
  assign op_b     = use_rs2 ? rs2_val : imm;
  assign alu_res  = alu(alu_op, op_a, op_b);
  assign taken    = br_cmp(br_op, rs1_val, rs2_val);
  assign pc_plus4 = i_pc + 32'd4;

  assign wb_data = is_load ? i_load_data :
                   (jump == JUMP_JAL || jump == JUMP_JALR) ? pc_plus4 : alu_res;
  assign we      = nreset && i_wb_en && writes_rd && legal && (rd != 5'd0);

  rv32i_regfile u_regfile (
    .i_clk  (i_clk),
    .nreset (nreset),
    .we     (we),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  assign o_mem_addr   = rs1_val + imm;
  assign o_store_data = rs2_val;
  assign o_load       = legal && is_load;
  assign o_store      = legal && is_store;
  assign o_jump       = legal ? jump : JUMP_SEQ;
  assign o_cond       = legal && (jump == JUMP_BRANCH) && taken;
  assign o_illegal    = !legal;

  // An illegal instruction holds the PC so the sequencer can trap on it.
  always_comb begin
    o_next_pc = pc_plus4;
    if (!legal) begin
      o_next_pc = i_pc;
    end else begin
      case (jump)
        JUMP_JAL:    o_next_pc = i_pc + imm;
        JUMP_JALR:   o_next_pc = {o_mem_addr[31:1], 1'b0};
        JUMP_BRANCH: if (taken) o_next_pc = i_pc + imm;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_exec_datapath.sv
// Self-checking bench for rv32i_exec_datapath: directed cases then random instructions
// checked against an instruction-level reference model of RV32I.
module tb_rv32i_exec_datapath;

  logic        i_clk = 1'b0;
  logic        nreset;
  logic [31:0] i_insn, i_pc, i_load_data;
  logic        i_wb_en;
  logic [31:0] o_mem_addr, o_store_data, o_next_pc;
  logic        o_load, o_store, o_cond, o_illegal;
  logic [1:0]  o_jump;

  rv32i_exec_datapath dut (
    .i_clk       (i_clk),
    .nreset      (nreset),
    .i_insn      (i_insn),
    .i_pc        (i_pc),
    .i_wb_en     (i_wb_en),
    .i_load_data (i_load_data),
    .o_mem_addr  (o_mem_addr),
    .o_store_data(o_store_data),
    .o_load      (o_load),
    .o_store     (o_store),
    .o_jump      (o_jump),
    .o_cond      (o_cond),
    .o_next_pc   (o_next_pc),
    .o_illegal   (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_regs [32];

  typedef struct packed {
    logic        illegal, load, store;
    logic [1:0]  jump;
    logic        cond;
    logic [31:0] next_pc, addr, sdata;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } exp_t;

  exp_t cur_e;
  logic cur_wb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Reference arithmetic straight from the instruction-set rules.
  function automatic logic [31:0] ref_alu(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
    int unsigned sh = b % 32;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  function automatic exp_t model(logic [31:0] insn, logic [31:0] pc, logic [31:0] ld);
    exp_t        e;
    logic [2:0]  f3 = insn[14:12];
    logic [6:0]  f7 = insn[31:25];
    logic [31:0] a  = m_regs[insn[19:15]];
    logic [31:0] b  = m_regs[insn[24:20]];
    logic [31:0] ii = 32'($signed(insn[31:20]));
    logic [31:0] is = 32'($signed({insn[31:25], insn[11:7]}));
    logic [31:0] ib = 32'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}));
    logic [31:0] ij = 32'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));
    logic [31:0] iu = {insn[31:12], 12'h000};
    logic        ok = 1'b0;
    e = '0;
    e.rd = insn[11:7];
    e.sdata = b;
    e.next_pc = pc + 4;
    case (insn[6:0])
      7'b0110111: begin ok = 1; e.wr = 1; e.wdata = iu; end
      7'b0010111: begin ok = 1; e.wr = 1; e.wdata = pc + iu; end
      7'b1101111: begin ok = 1; e.jump = 2'b01; e.next_pc = pc + ij; e.wr = 1; e.wdata = pc + 4; end
      7'b1100111: begin
        ok = (f3 == 0); e.jump = 2'b10; e.next_pc = (a + ii) & ~32'd1; e.wr = 1; e.wdata = pc + 4;
      end
      7'b1100011: begin
        ok = (f3 != 2) && (f3 != 3); e.jump = 2'b11;
        e.cond = ref_taken(f3, a, b);
        if (e.cond) e.next_pc = pc + ib;
      end
      7'b0000011: begin ok = (f3 == 2); e.load = 1; e.addr = a + ii; e.wr = 1; e.wdata = ld; end
      7'b0100011: begin ok = (f3 == 2); e.store = 1; e.addr = a + is; end
      7'b0010011: begin
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        e.wr = 1; e.wdata = ref_alu(f3, (f3 == 5) && (f7 == 7'h20), a, ii);
      end
      7'b0110011: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.wr = 1; e.wdata = ref_alu(f3, f7 == 7'h20, a, b);
      end
      7'b0001111: ok = (f3 == 0);
      default: ok = 0;
    endcase
    if (!ok) begin
      e.load = 0; e.store = 0; e.jump = 0; e.cond = 0; e.next_pc = pc; e.wr = 0;
    end
    e.illegal = !ok;
    return e;
  endfunction

  // Drives one instruction mid-cycle and checks combinational outputs against the model.
  task automatic issue(input logic [31:0] insn, input logic [31:0] pc,
                       input logic [31:0] ld, input logic wb);
    i_insn = insn; i_pc = pc; i_load_data = ld; i_wb_en = wb;
    cur_e  = model(insn, pc, ld);
    cur_wb = wb;
    #2;
    chk($sformatf("illegal %08h", insn), {31'd0, o_illegal}, {31'd0, cur_e.illegal});
    chk($sformatf("load %08h", insn), {31'd0, o_load}, {31'd0, cur_e.load});
    chk($sformatf("store %08h", insn), {31'd0, o_store}, {31'd0, cur_e.store});
    chk($sformatf("jump %08h", insn), {30'd0, o_jump}, {30'd0, cur_e.jump});
    chk($sformatf("cond %08h", insn), {31'd0, o_cond}, {31'd0, cur_e.cond});
    chk($sformatf("next_pc %08h", insn), o_next_pc, cur_e.next_pc);
    chk($sformatf("store_data %08h", insn), o_store_data, cur_e.sdata);
    if (cur_e.load || cur_e.store)
      chk($sformatf("mem_addr %08h", insn), o_mem_addr, cur_e.addr);
  endtask

  task automatic commit();
    @(posedge i_clk);
    if (cur_wb && cur_e.wr && cur_e.rd != 5'd0) m_regs[cur_e.rd] = cur_e.wdata;
    #1;
  endtask

  task automatic exec(input logic [31:0] insn, input logic [31:0] pc,
                      input logic [31:0] ld, input logic wb);
    issue(insn, pc, ld, wb);
    commit();
  endtask

  // Reads register k through the store-data port of SW xk,0(x0).
  task automatic probe(input int k, input logic [31:0] exp);
    i_insn = enc_s(12'd0, 5'(k), 5'd0); i_wb_en = 1'b0;
    #2;
    chk($sformatf("probe x%0d", k), o_store_data, exp);
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    i_insn = enc_i(12'd9, 5'd0, 3'd0, 5'd7, 7'b0010011);
    i_wb_en = 1'b1;
    @(posedge i_clk); #1;
    foreach (m_regs[k]) m_regs[k] = '0;
    nreset = 1'b1;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] r   = $urandom;
    logic [4:0]  rd  = 5'($urandom_range(0, 7));
    logic [4:0]  rs1 = 5'($urandom_range(0, 7));
    logic [4:0]  rs2 = 5'($urandom_range(0, 7));
    logic [2:0]  f3  = 3'($urandom_range(0, 7));
    logic        odd = ($urandom_range(0, 3) == 0);
    logic [6:0]  f7;
    logic [31:0] insn;
    case ($urandom_range(0, 3))
      0: f7 = 7'h20;
      3: f7 = r[31:25];
      default: f7 = 7'h00;
    endcase
    case ($urandom_range(0, 12))
      0:  insn = {r[31:12], rd, 7'b0110111};
      1:  insn = {r[31:12], rd, 7'b0010111};
      2:  insn = {r[31:12], rd, 7'b1101111};
      3:  insn = {r[31:20], rs1, odd ? f3 : 3'd0, rd, 7'b1100111};
      4:  insn = {r[31:25], rs2, rs1, f3, r[11:7], 7'b1100011};
      5:  insn = {r[31:20], rs1, odd ? f3 : 3'd2, rd, 7'b0000011};
      6:  insn = {r[31:25], rs2, rs1, odd ? f3 : 3'd2, r[11:7], 7'b0100011};
      7, 8: insn = {(f3 == 3'd1 || f3 == 3'd5) ? {f7, r[24:20]} : r[31:20], rs1, f3, rd, 7'b0010011};
      9, 10: insn = {f7, rs2, rs1, f3, rd, 7'b0110011};
      11: insn = {r[31:15], odd ? f3 : 3'd0, r[11:7], 7'b0001111};
      default: insn = r;
    endcase
    return insn;
  endfunction

  initial begin
    logic [31:0] pc0 = 32'h8000_0000;
    logic [31:0] pc;
    i_pc = pc0; i_load_data = '0;
    do_reset();
    for (int k = 0; k < 32; k += 5) probe(k, 32'd0);

    // 1) ADDI x1,x0,5
    issue(32'h0050_0093, pc0, 32'd0, 1'b1);
    chk("t1 next_pc", o_next_pc, 32'h8000_0004);
    commit();
    probe(1, 32'd5);

    // 2) SUB / SLT / SLTU / SRAI
    exec(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'b0010011), pc0, 32'd0, 1'b1);
    exec(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), pc0, 32'd0, 1'b1);
    probe(3, 32'd8);
    exec(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), pc0, 32'd0, 1'b1);
    probe(3, 32'd0);
    exec(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3), pc0, 32'd0, 1'b1);
    probe(3, 32'd1);
    exec(enc_i({7'h20, 5'd1}, 5'd2, 3'd5, 5'd2, 7'b0010011), pc0, 32'd0, 1'b1);
    probe(2, 32'hFFFF_FFFE);

    // 3) BEQ taken, BNE not taken
    issue(enc_b(13'd16, 5'd1, 5'd1, 3'd0), pc0, 32'd0, 1'b1);
    chk("t3 beq cond", {31'd0, o_cond}, 32'd1);
    chk("t3 beq next_pc", o_next_pc, 32'h8000_0010);
    commit();
    issue(enc_b(13'd16, 5'd1, 5'd1, 3'd1), pc0, 32'd0, 1'b1);
    chk("t3 bne cond", {31'd0, o_cond}, 32'd0);
    chk("t3 bne next_pc", o_next_pc, 32'h8000_0004);
    commit();

    // 4) JALR x1,x2,3 with x2 = 0x100
    exec(enc_i(12'h100, 5'd0, 3'd0, 5'd2, 7'b0010011), pc0, 32'd0, 1'b1);
    issue(enc_i(12'd3, 5'd2, 3'd0, 5'd1, 7'b1100111), 32'h8000_0020, 32'd0, 1'b1);
    chk("t4 jalr next_pc", o_next_pc, 32'h0000_0102);
    commit();
    probe(1, 32'h8000_0024);

    // 5) SW x2,8(x1); LW x5,0(x1)
    issue(enc_s(12'd8, 5'd2, 5'd1), pc0, 32'd0, 1'b1);
    chk("t5 sw store", {31'd0, o_store}, 32'd1);
    chk("t5 sw addr", o_mem_addr, 32'h8000_002C);
    chk("t5 sw data", o_store_data, 32'h0000_0100);
    commit();
    issue(enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011), pc0, 32'hDEAD_BEEF, 1'b1);
    chk("t5 lw load", {31'd0, o_load}, 32'd1);
    commit();
    probe(5, 32'hDEAD_BEEF);

    // 6) ECALL and LB are illegal; x0 never changes
    issue(32'h0000_0073, 32'h8000_0040, 32'd0, 1'b1);
    chk("t6 ecall illegal", {31'd0, o_illegal}, 32'd1);
    chk("t6 ecall next_pc", o_next_pc, 32'h8000_0040);
    commit();
    issue(enc_i(12'd0, 5'd1, 3'd0, 5'd5, 7'b0000011), pc0, 32'h1234_5678, 1'b1);
    chk("t6 lb illegal", {31'd0, o_illegal}, 32'd1);
    commit();
    probe(5, 32'hDEAD_BEEF);
    exec(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'b0010011), pc0, 32'd0, 1'b1);
    probe(0, 32'd0);

    // Random instruction stream, with periodic resets that must clear x1..x7.
    for (int n = 0; n < 600; n++) begin
      pc = $urandom;
      pc[1:0] = 2'b00;
      exec(rand_insn(), pc, $urandom, $urandom_range(0, 7) != 0);
      if (n % 150 == 149) begin
        do_reset();
        for (int k = 1; k < 8; k++) probe(k, 32'd0);
      end
    end
    for (int k = 0; k < 8; k++) probe(k, m_regs[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
